// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : registered add/subtract unit for the single-cycle RISC datapath.
//
// Computes ADD, ADC, SUB or SBB on A and B through one ripple-carry adder
// (S = A + Bop + cin) and registers the result with a latency of one cycle.
// A new operation is accepted every cycle.
//
// Ports
//   clk    : system clock, rising-edge active
//   rst    : asynchronous reset, active-high; clears Y, Cout and Cout_1
//   A      : operand A (minuend for SUB/SBB)
//   B      : operand B (subtrahend for SUB/SBB)
//   SBB    : subtract with borrow   (highest priority)
//   SUB    : subtract
//   ADC    : add with carry
//   C      : carry flag input, used by ADC/SBB only
//   Y      : registered result, wraps modulo 2^WIDTH
//   Cout   : registered carry out of bit WIDTH-1 (1 = no borrow on subtract)
//   Cout_1 : registered carry out of bit WIDTH-2 (carry into the MSB);
//            overflow downstream is Cout ^ Cout_1
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SBB,
  input  logic             SUB,
  input  logic             C,
  input  logic             ADC,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             Cout_1
);

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] y_d,     y_q;
  logic             cout_d,  cout_q;
  logic             cout1_d, cout1_q;

  // Operand select, fixed priority SBB > SUB > ADC > ADD.
  // Subtraction is A + ~B + 1; the borrow variant drops the +1 when C is set,
  // so Cout keeps its natural "no borrow" meaning and is never inverted.
  always_comb begin
    b_op = B;
    cin  = 1'b0;
    if (SBB) begin
      b_op = ~B;
      cin  = ~C;
    end else if (SUB) begin
      b_op = ~B;
      cin  = 1'b1;
    end else if (ADC) begin
      b_op = B;
      cin  = C;
    end
  end

  // Explicit ripple chain so the carry out of bit WIDTH-2 is directly visible.
  always_comb begin
    carry    = '0;
    y_d      = '0;
    carry[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      y_d[i]     = A[i] ^ b_op[i] ^ carry[i];
      carry[i+1] = (A[i] & b_op[i]) | (A[i] & carry[i]) | (b_op[i] & carry[i]);
    end
    cout_d  = carry[WIDTH];
    cout1_d = carry[WIDTH-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      cout_q  <= 1'b0;
      cout1_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      cout_q  <= cout_d;
      cout1_q <= cout1_d;
    end
  end

  assign Y      = y_q;
  assign Cout   = cout_q;
  assign Cout_1 = cout1_q;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : self-checking bench for alu.
// Directed steps from the test plan followed by randomized operations, all
// checked against an arithmetic reference model (integer add/subtract and
// magnitude compares, no gate-level carry chain).
// ---------------------------------------------------------------------------
module tb_alu;

  logic        clk;
  logic        rst;
  logic [15:0] A, B;
  logic        SBB, SUB, C, ADC;
  logic [15:0] Y;
  logic        Cout, Cout_1;

  int n_assert;
  int n_fail;

  alu #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .SBB    (SBB),
    .SUB    (SUB),
    .C      (C),
    .ADC    (ADC),
    .Y      (Y),
    .Cout   (Cout),
    .Cout_1 (Cout_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operation's meaning.
  // Subtract: carry out = "no borrow" = minuend >= subtrahend + borrow,
  // applied to the full word (Cout) and to the low 15 bits (Cout_1).
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       input logic sbb, input logic sub, input logic adc,
                       input logic c, output logic [15:0] ey,
                       output logic ec, output logic ec1);
    int unsigned ai, bi, al, bl, k;
    ai = a; bi = b; al = a & 16'h7FFF; bl = b & 16'h7FFF;
    if (sbb || sub) begin
      k   = (sbb && c) ? 1 : 0;
      ey  = 16'((ai - bi - k) & 32'hFFFF);
      ec  = (ai >= bi + k);
      ec1 = (al >= bl + k);
    end else begin
      k   = (adc && c) ? 1 : 0;
      ey  = 16'((ai + bi + k) & 32'hFFFF);
      ec  = ((ai + bi + k) >= 32'h10000);
      ec1 = ((al + bl + k) >= 32'h8000);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] ey,
                     input logic ec, input logic ec1);
    n_assert++;
    assert (Y === ey) else begin
      n_fail++;
      $error("FAIL %s Y observed=%h expected=%h", tag, Y, ey);
    end
    n_assert++;
    assert (Cout === ec) else begin
      n_fail++;
      $error("FAIL %s Cout observed=%b expected=%b", tag, Cout, ec);
    end
    n_assert++;
    assert (Cout_1 === ec1) else begin
      n_fail++;
      $error("FAIL %s Cout_1 observed=%b expected=%b", tag, Cout_1, ec1);
    end
  endtask

  // Drive one operation away from the edge, clock it, check 1 ns later.
  task automatic op(input string tag, input logic [15:0] a, input logic [15:0] b,
                    input logic sbb, input logic sub, input logic adc,
                    input logic c);
    logic [15:0] ey;
    logic        ec, ec1;
    @(negedge clk);
    A = a; B = b; SBB = sbb; SUB = sub; ADC = adc; C = c;
    model(a, b, sbb, sub, adc, c, ey, ec, ec1);
    @(posedge clk);
    #1;
    chk(tag, ey, ec, ec1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    A = '0; B = '0; SBB = 0; SUB = 0; ADC = 0; C = 0;

    // Reset state, held across clock edges.
    #3;
    chk("reset_async", 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed steps with literal expectations from the test plan.
    op("noselect_zero", 16'h0000, 16'h0000, 0, 0, 0, 0);
    chk("lit_zero", 16'h0000, 1'b0, 1'b0);
    op("sbb_c0", 16'h4567, 16'h1234, 1, 0, 0, 0);
    chk("lit_sbb_c0", 16'h3333, 1'b1, 1'b1);
    op("sbb_c1", 16'h4567, 16'h1234, 1, 0, 0, 1);
    chk("lit_sbb_c1", 16'h3332, 1'b1, 1'b1);
    op("sub", 16'h4567, 16'h1234, 0, 1, 0, 0);
    chk("lit_sub", 16'h3333, 1'b1, 1'b1);
    op("sub_ignores_c", 16'h4567, 16'h1234, 0, 1, 0, 1);
    chk("lit_sub_c1", 16'h3333, 1'b1, 1'b1);
    op("adc_c0", 16'h4567, 16'h1234, 0, 0, 1, 0);
    chk("lit_adc_c0", 16'h579B, 1'b0, 1'b0);
    op("adc_c1", 16'h4567, 16'h1234, 0, 0, 1, 1);
    chk("lit_adc_c1", 16'h579C, 1'b0, 1'b0);
    op("add_ignores_c", 16'h4567, 16'h1234, 0, 0, 0, 1);
    chk("lit_add_c1", 16'h579B, 1'b0, 1'b0);
    op("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 0, 0);
    chk("lit_add_ovf", 16'h8000, 1'b0, 1'b1);
    op("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 0, 0);
    chk("lit_add_wrap", 16'h0000, 1'b1, 1'b1);
    op("sub_wrap", 16'h0000, 16'h0001, 0, 1, 0, 0);
    chk("lit_sub_wrap", 16'hFFFF, 1'b0, 1'b0);
    op("all_sel_c1", 16'h4567, 16'h1234, 1, 1, 1, 1);
    chk("lit_all_sel", 16'h3332, 1'b1, 1'b1);
    op("sub_adc_pri", 16'h4567, 16'h1234, 0, 1, 1, 1);
    chk("lit_sub_adc", 16'h3333, 1'b1, 1'b1);

    // Reset pulsed between edges: clears at once, in-flight result discarded.
    @(negedge clk);
    A = 16'h1111; B = 16'h2222; SBB = 0; SUB = 0; ADC = 0; C = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_midcycle", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_over_edge", 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    op("after_rst", 16'h1111, 16'h2222, 0, 0, 0, 0);
    chk("lit_after_rst", 16'h3333, 1'b0, 1'b0);

    // Randomized operations against the model.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic [3:0]  sel;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if (i % 8 == 0) ra = 16'hFFFF;
      if (i % 8 == 1) rb = 16'hFFFF;
      if (i % 8 == 2) ra = 16'h8000;
      sel = 4'($urandom_range(0, 15));
      op("random", ra, rb, sel[0] & sel[1], sel[1], sel[2], sel[3]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 16-bit registered add/subtract unit for the single-cycle RISC datapath.
- Computes ADD, ADC (add with carry), SUB and SBB (subtract with borrow) on operands A and B, using the incoming carry flag C.
- Outputs the 16-bit result Y, the carry out of bit 15 (Cout) and the carry out of bit 14 (Cout_1). Cout_1 is the carry into bit 15; downstream flag logic computes overflow as Cout XOR Cout_1.
- Inputs are sampled on the clock edge; outputs are registered.

Parameters:
- WIDTH, 16, operand/result width. Cout_1 is always the carry out of bit WIDTH-2.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-high
- A  input  16  operand A (minuend for SUB/SBB)
- B  input  16  operand B (subtrahend for SUB/SBB)
- SBB  input  1  select subtract-with-borrow
- SUB  input  1  select subtract
- C  input  1  carry flag input (used by ADC/SBB only)
- ADC  input  1  select add-with-carry
- Y  output  16  registered result
- Cout  output  1  registered carry out of bit 15
- Cout_1  output  1  registered carry out of bit 14 (carry into bit 15)

Behaviour:
- Reset: rst high immediately forces Y=0, Cout=0, Cout_1=0, independent of clk. These values are held while rst is high. The first capture happens on the first rising clk edge after rst deasserts.
- Latency: 1 cycle. Inputs present before rising edge N are reflected on Y/Cout/Cout_1 after edge N. There is no handshake; a new operation is accepted every cycle.
- Datapath: one 16-bit ripple-carry adder computing S = A + Bop + cin.
  - Cout = carry out of bit 15.
  - Cout_1 = carry out of bit 14.
  - Y = S[15:0], wrapping modulo 2^16.
- Operation select, fixed priority SBB > SUB > ADC > default ADD:
  - SBB=1: Bop=~B, cin=~C. Result is Y = A - B - C.
  - SUB=1 (SBB=0): Bop=~B, cin=1. Result is Y = A - B.
  - ADC=1 (SBB=SUB=0): Bop=B, cin=C. Result is Y = A + B + C.
  - All selects 0: Bop=B, cin=0. Result is Y = A + B.
- Carry convention: for subtraction, Cout=1 means no borrow; Cout=0 means a borrow occurred. Cout is not inverted for subtraction.
- Multiple selects high: the priority above applies. Lower-priority selects are ignored.
- C is ignored for ADD and SUB.
- Wrap-around:
  - 0xFFFF + 0x0001 gives Y=0x0000, Cout=1.
  - 0x0000 - 0x0001 gives Y=0xFFFF, Cout=0.
- Reset asserted mid-operation: outputs clear asynchronously and the in-flight result is discarded.
- X or Z on the select lines is not supported; the operation performed is then undefined.

Test Plan:
- Reset with all inputs 0, then one clock edge with no select -> Y=0x0000, Cout=0, Cout_1=0.
- A=0x4567, B=0x1234, SBB=1, C=0 -> after 1 edge: Y=0x3333, Cout=1, Cout_1=1.
- Same operands, SBB=1, C=1 -> Y=0x3332, Cout=1, Cout_1=1.
- Same operands, SUB=1, C=0 -> Y=0x3333, Cout=1, Cout_1=1.
- Same operands, ADC=1:
  - C=0 -> Y=0x579B, Cout=0, Cout_1=0.
  - C=1 -> Y=0x579C, Cout=0, Cout_1=0.
- Boundary checks:
  - A=0x7FFF, B=0x0001, ADD -> Y=0x8000, Cout=0, Cout_1=1 (overflow).
  - A=0xFFFF, B=0x0001, ADD -> Y=0x0000, Cout=1.
  - A=0x0000, B=0x0001, SUB -> Y=0xFFFF, Cout=0.
  - SBB=SUB=ADC=1 with C=1 -> SBB result.
  - rst pulsed between clock edges -> outputs 0 immediately.
